// File: rtl/bsg_fifo_1r1w_rolly_replay.sv
// 1r1w FIFO with transactional pointers on both sides.
//
// Write side: enqueues stay speculative until w_commit_i. w_drop_i discards every
// uncommitted write. Read side: dequeues stay speculative until r_release_i.
// r_rewind_i replays every unreleased entry.
//
// Ports:
//   clk_i, reset_i        clock, synchronous active-high reset
//   data_i, v_i, ready_o  write data / valid / space available
//   w_commit_i, w_drop_i  commit / discard speculative writes (incl. same-cycle enq)
//   data_o, v_o, yumi_i   head data at speculative read pointer / valid / dequeue
//   r_release_i           release dequeued entries (incl. same-cycle yumi)
//   r_rewind_i            move read pointer back to the last release point
//   free_els_o            writable slots: els - (wptr - rcptr)
//   commit_els_o          committed entries not yet dequeued: wcptr - rptr
module bsg_fifo_1r1w_rolly_replay #(
  parameter int unsigned width_p            = 8,
  parameter int unsigned lg_size_p          = 2,
  parameter bit          ready_THEN_valid_p = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 reset_i,

  input  logic [width_p-1:0]   data_i,
  input  logic                 v_i,
  output logic                 ready_o,
  input  logic                 w_commit_i,
  input  logic                 w_drop_i,

  output logic [width_p-1:0]   data_o,
  output logic                 v_o,
  input  logic                 yumi_i,
  input  logic                 r_release_i,
  input  logic                 r_rewind_i,

  output logic [lg_size_p:0]   free_els_o,
  output logic [lg_size_p:0]   commit_els_o
);

  localparam int unsigned Els = 1 << lg_size_p;

  typedef logic [lg_size_p:0] ptr_t;

  localparam ptr_t ElsPtr = ptr_t'(Els);

  // MSB of each pointer is the wrap bit; low bits address the array.
  ptr_t wptr_q, wptr_d;
  ptr_t wcptr_q, wcptr_d;
  ptr_t rptr_q, rptr_d;
  ptr_t rcptr_q, rcptr_d;

  logic [width_p-1:0] mem_q [Els];

  logic full, empty, enq;
  ptr_t wptr_inc, rptr_inc, occupied;

  always_comb begin
    // Occupancy counts from rcptr so rewound-but-unreleased entries keep their slots.
    occupied = wptr_q - rcptr_q;
    full     = (occupied == ElsPtr);
    empty    = (rptr_q == wcptr_q);
    enq      = ready_THEN_valid_p ? v_i : (v_i & ~full);

    wptr_inc = wptr_q + ptr_t'(enq);
    rptr_inc = rptr_q + ptr_t'(yumi_i);

    wptr_d  = w_drop_i   ? wcptr_q  : wptr_inc;
    wcptr_d = w_commit_i ? wptr_inc : wcptr_q;

    // Release wins over rewind: both pointers land on the same spot (no-op replay).
    rcptr_d = r_release_i ? rptr_inc : rcptr_q;
    if (r_release_i) begin
      rptr_d = rptr_inc;
    end else if (r_rewind_i) begin
      rptr_d = rcptr_q;
    end else begin
      rptr_d = rptr_inc;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q  <= '0;
      wcptr_q <= '0;
      rptr_q  <= '0;
      rcptr_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      wcptr_q <= wcptr_d;
      rptr_q  <= rptr_d;
      rcptr_q <= rcptr_d;
    end
  end

  // A write that is dropped in the same cycle lands past wcptr and is never read.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      mem_q[wptr_q[lg_size_p-1:0]] <= data_i;
    end
  end

  assign ready_o      = ~full;
  assign v_o          = ~empty;
  assign data_o       = mem_q[rptr_q[lg_size_p-1:0]];
  assign free_els_o   = ElsPtr - occupied;
  assign commit_els_o = wcptr_q - rptr_q;

`ifndef SYNTHESIS
  a_commit_drop: assert property (@(posedge clk_i) disable iff (reset_i)
    !(w_commit_i && w_drop_i))
    else $error("w_commit_i and w_drop_i asserted together");

  a_yumi_valid: assert property (@(posedge clk_i) disable iff (reset_i)
    !(yumi_i && !v_o))
    else $error("yumi_i asserted while v_o is low");

  a_ready_valid: assert property (@(posedge clk_i) disable iff (reset_i)
    !(ready_THEN_valid_p && v_i && !ready_o))
    else $error("v_i asserted while ready_o is low");
`endif

endmodule

// File: tb/tb_bsg_fifo_1r1w_rolly_replay.sv
// Bench for bsg_fifo_1r1w_rolly_replay: three instances (lg_size_p = 1, 2, 3), directed
// scenarios on the depth-4 instance, reset-mid-stream on the depth-8 instance, and
// randomized stress on depths 2 and 8 against a queue model.
module tb_bsg_fifo_1r1w_rolly_replay;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst  [3];
  logic [7:0] din  [3];
  logic       vin  [3];
  logic       wc   [3];
  logic       wd   [3];
  logic       yumi [3];
  logic       rrel [3];
  logic       rrew [3];

  wire        rdy      [3];
  wire        vo       [3];
  wire  [7:0] dout     [3];
  wire  [7:0] free_e   [3];
  wire  [7:0] commit_e [3];

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q [$];

  // Stress model: uncommitted writes, committed-unreleased entries, speculative read offset.
  logic [7:0] m_spec [$];
  logic [7:0] m_all  [$];
  int         m_rd;
  int         m_rel_total;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [g+1:0] fw, cw;
    bsg_fifo_1r1w_rolly_replay #(
      .width_p           (8),
      .lg_size_p         (g + 1),
      .ready_THEN_valid_p(1'b0)
    ) u_dut (
      .clk_i       (clk),
      .reset_i     (rst[g]),
      .data_i      (din[g]),
      .v_i         (vin[g]),
      .ready_o     (rdy[g]),
      .w_commit_i  (wc[g]),
      .w_drop_i    (wd[g]),
      .data_o      (dout[g]),
      .v_o         (vo[g]),
      .yumi_i      (yumi[g]),
      .r_release_i (rrel[g]),
      .r_rewind_i  (rrew[g]),
      .free_els_o  (fw),
      .commit_els_o(cw)
    );
    assign free_e[g]   = 8'(fw);
    assign commit_e[g] = 8'(cw);
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int k);
    din[k]  = 8'h00;
    vin[k]  = 1'b0;
    wc[k]   = 1'b0;
    wd[k]   = 1'b0;
    yumi[k] = 1'b0;
    rrel[k] = 1'b0;
    rrew[k] = 1'b0;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      idle(k);
      rst[k] = 1'b1;
    end
    tick();
    tick();
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (rdy[k] !== 1'b1) begin
          failures++;
          $display("FAIL reset_ready k=%0d pass=%0d got=%b exp=1", k, pass, rdy[k]);
        end
        checks++;
        if (vo[k] !== 1'b0) begin
          failures++;
          $display("FAIL reset_v k=%0d pass=%0d got=%b exp=0", k, pass, vo[k]);
        end
        checks++;
        if (int'(free_e[k]) !== (1 << (k + 1))) begin
          failures++;
          $display("FAIL reset_free k=%0d pass=%0d got=%0d exp=%0d", k, pass, free_e[k],
                   1 << (k + 1));
        end
        checks++;
        if (commit_e[k] !== 8'd0) begin
          failures++;
          $display("FAIL reset_commit k=%0d pass=%0d got=%0d exp=0", k, pass, commit_e[k]);
        end
      end
      for (int k = 0; k < 3; k++) rst[k] = 1'b0;
      tick();
    end
  endtask

  task automatic test_basic_commit();
    vin[1] = 1'b1;
    din[1] = 8'h11;
    tick();
    din[1] = 8'h22;
    wc[1]  = 1'b1;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    checks++;
    if (vo[1] !== 1'b0) begin
      failures++;
      $display("FAIL basic_v_before_commit got=%b exp=0", vo[1]);
    end
    tick();
    idle(1);
    checks++;
    if (vo[1] !== 1'b1) begin
      failures++;
      $display("FAIL basic_v_after_commit got=%b exp=1", vo[1]);
    end
    checks++;
    if (commit_e[1] !== 8'd2) begin
      failures++;
      $display("FAIL basic_commit_els got=%0d exp=2", commit_e[1]);
    end
    checks++;
    if (free_e[1] !== 8'd2) begin
      failures++;
      $display("FAIL basic_free_before_release got=%0d exp=2", free_e[1]);
    end
    for (int i = 0; i < 2; i++) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      checks++;
      if (dout[1] !== e) begin
        failures++;
        $display("FAIL basic_data i=%0d got=%h exp=%h", i, dout[1], e);
      end
      yumi[1] = 1'b1;
      tick();
      yumi[1] = 1'b0;
      checks++;
      if (int'(commit_e[1]) !== 1 - i) begin
        failures++;
        $display("FAIL basic_commit_dec i=%0d got=%0d exp=%0d", i, commit_e[1], 1 - i);
      end
    end
    rrel[1] = 1'b1;
    tick();
    rrel[1] = 1'b0;
    checks++;
    if (free_e[1] !== 8'd4) begin
      failures++;
      $display("FAIL basic_free_after_release got=%0d exp=4", free_e[1]);
    end
  endtask

  task automatic test_drop();
    vin[1] = 1'b1; din[1] = 8'hA1; wc[1] = 1'b1;
    exp_q.push_back(8'hA1);
    tick();
    wc[1] = 1'b0; din[1] = 8'hB2;
    tick();
    din[1] = 8'hC3;
    tick();
    vin[1] = 1'b0; wd[1] = 1'b1;
    tick();
    wd[1] = 1'b0; vin[1] = 1'b1; din[1] = 8'hD4; wc[1] = 1'b1;
    exp_q.push_back(8'hD4);
    tick();
    idle(1);
    checks++;
    if (commit_e[1] !== 8'd2) begin
      failures++;
      $display("FAIL drop_commit_els got=%0d exp=2", commit_e[1]);
    end
    checks++;
    if (free_e[1] !== 8'd2) begin
      failures++;
      $display("FAIL drop_free got=%0d exp=2", free_e[1]);
    end
    while (exp_q.size() > 0) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      checks++;
      if (vo[1] !== 1'b1 || dout[1] !== e) begin
        failures++;
        $display("FAIL drop_data got=%h v=%b exp=%h", dout[1], vo[1], e);
      end
      yumi[1] = vo[1];
      rrel[1] = 1'b1;
      tick();
      idle(1);
    end
    checks++;
    if (vo[1] !== 1'b0 || free_e[1] !== 8'd4) begin
      failures++;
      $display("FAIL drop_drained v=%b free=%0d exp v=0 free=4", vo[1], free_e[1]);
    end
  endtask

  task automatic test_full_release();
    for (int i = 0; i < 4; i++) begin
      vin[1] = 1'b1; din[1] = 8'h30 + 8'(i); wc[1] = 1'b1;
      exp_q.push_back(8'h30 + 8'(i));
      tick();
    end
    idle(1);
    checks++;
    if (rdy[1] !== 1'b0 || free_e[1] !== 8'd0) begin
      failures++;
      $display("FAIL full_flag ready=%b free=%0d exp ready=0 free=0", rdy[1], free_e[1]);
    end
    // A write attempt while full is ignored.
    vin[1] = 1'b1; din[1] = 8'hEE; wc[1] = 1'b1;
    tick();
    idle(1);
    checks++;
    if (commit_e[1] !== 8'd4) begin
      failures++;
      $display("FAIL full_enq_ignored commit=%0d exp=4", commit_e[1]);
    end
    for (int i = 0; i < 4; i++) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      checks++;
      if (dout[1] !== e) begin
        failures++;
        $display("FAIL full_data i=%0d got=%h exp=%h", i, dout[1], e);
      end
      yumi[1] = 1'b1;
      tick();
      yumi[1] = 1'b0;
      checks++;
      if (rdy[1] !== 1'b0) begin
        failures++;
        $display("FAIL full_ready_unreleased i=%0d got=%b exp=0", i, rdy[1]);
      end
    end
    rrel[1] = 1'b1;
    tick();
    rrel[1] = 1'b0;
    checks++;
    if (rdy[1] !== 1'b1 || free_e[1] !== 8'd4) begin
      failures++;
      $display("FAIL full_release ready=%b free=%0d exp ready=1 free=4", rdy[1], free_e[1]);
    end
  endtask

  task automatic test_rewind();
    for (int i = 1; i <= 3; i++) begin
      vin[1] = 1'b1; din[1] = 8'(i); wc[1] = 1'b1;
      tick();
    end
    idle(1);
    for (int i = 1; i <= 2; i++) begin
      checks++;
      if (dout[1] !== 8'(i)) begin
        failures++;
        $display("FAIL rewind_first_pass i=%0d got=%h exp=%h", i, dout[1], 8'(i));
      end
      yumi[1] = 1'b1;
      tick();
      yumi[1] = 1'b0;
    end
    // Rewind with a same-cycle yumi on entry 3: the yumi is ignored.
    yumi[1] = 1'b1; rrew[1] = 1'b1;
    tick();
    idle(1);
    checks++;
    if (dout[1] !== 8'd1 || commit_e[1] !== 8'd3) begin
      failures++;
      $display("FAIL rewind_replay data=%h commit=%0d exp data=01 commit=3", dout[1], commit_e[1]);
    end
    yumi[1] = 1'b1;
    tick();
    checks++;
    if (dout[1] !== 8'd2) begin
      failures++;
      $display("FAIL rewind_replay2 got=%h exp=02", dout[1]);
    end
    rrel[1] = 1'b1;
    tick();
    idle(1);
    checks++;
    if (free_e[1] !== 8'd3 || dout[1] !== 8'd3) begin
      failures++;
      $display("FAIL rewind_release free=%0d data=%h exp free=3 data=03", free_e[1], dout[1]);
    end
    // Rewind right after a release point is a no-op.
    rrew[1] = 1'b1;
    tick();
    idle(1);
    checks++;
    if (dout[1] !== 8'd3 || commit_e[1] !== 8'd1) begin
      failures++;
      $display("FAIL rewind_noop data=%h commit=%0d exp data=03 commit=1", dout[1], commit_e[1]);
    end
    yumi[1] = 1'b1; rrel[1] = 1'b1; rrew[1] = 1'b1;
    tick();
    idle(1);
    checks++;
    if (vo[1] !== 1'b0 || free_e[1] !== 8'd4) begin
      failures++;
      $display("FAIL rewind_drain v=%b free=%0d exp v=0 free=4", vo[1], free_e[1]);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      vin[2] = 1'b1; din[2] = 8'h50 + 8'(i); wc[2] = (i == 1);
      tick();
    end
    idle(2);
    checks++;
    if (vo[2] !== 1'b1 || free_e[2] !== 8'd3 || commit_e[2] !== 8'd2) begin
      failures++;
      $display("FAIL resetmid_pre v=%b free=%0d commit=%0d exp v=1 free=3 commit=2",
               vo[2], free_e[2], commit_e[2]);
    end
    rst[2] = 1'b1;
    tick();
    rst[2] = 1'b0;
    checks++;
    if (vo[2] !== 1'b0 || rdy[2] !== 1'b1 || free_e[2] !== 8'd8 || commit_e[2] !== 8'd0) begin
      failures++;
      $display("FAIL resetmid_post v=%b ready=%b free=%0d commit=%0d exp v=0 ready=1 free=8 commit=0",
               vo[2], rdy[2], free_e[2], commit_e[2]);
    end
  endtask

  task automatic test_stress(input int k, input int cycles);
    int els;
    els = 1 << (k + 1);
    idle(k);
    rst[k] = 1'b1;
    tick();
    rst[k] = 1'b0;
    m_spec.delete();
    m_all.delete();
    m_rd = 0;
    m_rel_total = 0;
    for (int c = 0; c < cycles; c++) begin
      int  occ;
      bit  e_rdy, e_v, enq;
      int  r;
      occ   = m_all.size() + m_spec.size();
      e_rdy = occ < els;
      e_v   = m_rd < m_all.size();
      checks++;
      if (rdy[k] !== e_rdy) begin
        failures++;
        $display("FAIL stress_ready k=%0d cyc=%0d got=%b exp=%b", k, c, rdy[k], e_rdy);
      end
      checks++;
      if (vo[k] !== e_v) begin
        failures++;
        $display("FAIL stress_v k=%0d cyc=%0d got=%b exp=%b", k, c, vo[k], e_v);
      end
      checks++;
      if (int'(free_e[k]) !== els - occ) begin
        failures++;
        $display("FAIL stress_free k=%0d cyc=%0d got=%0d exp=%0d", k, c, free_e[k], els - occ);
      end
      checks++;
      if (int'(commit_e[k]) !== m_all.size() - m_rd) begin
        failures++;
        $display("FAIL stress_commit k=%0d cyc=%0d got=%0d exp=%0d", k, c, commit_e[k],
                 m_all.size() - m_rd);
      end
      if (e_v) begin
        checks++;
        if (dout[k] !== m_all[m_rd]) begin
          failures++;
          $display("FAIL stress_data k=%0d cyc=%0d got=%h exp=%h", k, c, dout[k], m_all[m_rd]);
        end
      end
      // Drive random stimulus.
      vin[k]  = ($urandom % 100) < 60;
      din[k]  = 8'($urandom);
      r       = $urandom % 100;
      wc[k]   = r < 30;
      wd[k]   = (r >= 30) && (r < 40);
      yumi[k] = e_v && (($urandom % 100) < 60);
      rrel[k] = ($urandom % 100) < 20;
      rrew[k] = ($urandom % 100) < 10;
      // Model next state.
      enq = vin[k] && e_rdy;
      if (enq) m_spec.push_back(din[k]);
      if (wd[k]) begin
        m_spec.delete();
      end else if (wc[k]) begin
        while (m_spec.size() > 0) m_all.push_back(m_spec.pop_front());
      end
      if (rrel[k]) begin
        int n;
        n = m_rd + int'(yumi[k]);
        for (int i = 0; i < n; i++) void'(m_all.pop_front());
        m_rel_total += n;
        m_rd = 0;
      end else if (rrew[k]) begin
        m_rd = 0;
      end else begin
        m_rd += int'(yumi[k]);
      end
      tick();
    end
    idle(k);
    checks++;
    if (m_rel_total / (2 * els) < 50) begin
      failures++;
      $display("FAIL stress_wraps k=%0d got=%0d exp>=50", k, m_rel_total / (2 * els));
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      idle(k);
      rst[k] = 1'b1;
    end
    @(negedge clk);
    test_reset();
    test_basic_commit();
    test_drop();
    test_full_release();
    test_rewind();
    test_reset_mid();
    test_stress(0, 10000);
    test_stress(2, 10000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bsg_fifo_1r1w_rolly_replay.md
Name: bsg_fifo_1r1w_rolly_replay

Overview:
- 1r1w FIFO with transactional pointers on both sides.
- Write side: enqueues are speculative until committed; a drop discards all uncommitted writes.
- Read side: dequeues are speculative until released; a rewind replays every unreleased entry.
- Sits between a packet producer that may abort mid-packet and a consumer that may need retransmission (e.g. a link layer with NACK).

Parameters:
- width_p, none (required), data width in bits.
- lg_size_p, none (required), log2 of depth; els = 2^lg_size_p; lg_size_p >= 1.
- ready_THEN_valid_p, 0, if 1 then enq = v_i and v_i must only be raised when ready_o = 1; if 0 then enq = v_i & ready_o.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  reset, synchronous, active-high.
- data_i  in  width_p  write data.
- v_i  in  1  write valid.
- ready_o  out  1  space available.
- w_commit_i  in  1  commit all speculative writes, including any enq in the same cycle.
- w_drop_i  in  1  discard all uncommitted writes, including any enq in the same cycle.
- data_o  out  width_p  head data at the speculative read pointer.
- v_o  out  1  committed, not-yet-dequeued data available.
- yumi_i  in  1  speculative dequeue.
- r_release_i  in  1  release all dequeued entries, including any yumi in the same cycle.
- r_rewind_i  in  1  rewind the read pointer to the last release point.
- free_els_o  out  lg_size_p+1  slots writable: els - (wptr - rcptr).
- commit_els_o  out  lg_size_p+1  committed entries not yet dequeued: wcptr - rptr.

Behaviour:
- Clock/reset: one clock, clk_i; reset_i is synchronous, active-high.
- State: four pointers of lg_size_p+1 bits (MSB is the wrap bit), plus an els x width_p array.
  - wptr: speculative write. wcptr: committed write. rptr: speculative read. rcptr: released read.
  - The memory address is the low lg_size_p bits; all arithmetic is modulo 2^(lg_size_p+1).
- Invariant: rcptr <= rptr <= wcptr <= wptr (modular order); wptr - rcptr <= els.
- Reset: all pointers 0. Outputs during and after reset: ready_o=1, v_o=0, free_els_o=els, commit_els_o=0. Memory contents are undefined.
- Flags:
  - full = (wptr - rcptr == els); ready_o = ~full.
  - empty = (rptr == wcptr); v_o = ~empty.
  - Rewound-but-unreleased entries keep their space, so full counts from rcptr.
- Enqueue: when enq, mem[wptr] <= data_i and wptr <= wptr+1 at the clock edge.
- Write commit: wcptr <= wptr + enq. Data enqueued in cycle N with w_commit_i in cycle N gives v_o=1 in cycle N+1 (one-cycle latency).
- Write drop: wptr <= wcptr; a same-cycle enq is discarded. The reader is unaffected because it never sees data past wcptr.
- Read: data_o = mem[rptr[lg_size_p-1:0]], combinational (asynchronous-read array), valid whenever v_o=1.
- Dequeue: yumi_i is legal only when v_o=1; rptr <= rptr+1.
- Release: rcptr <= rptr + yumi_i. Space freed by a release is visible on ready_o the next cycle.
- Rewind: rptr <= rcptr. A yumi in the same cycle is ignored, so that entry is replayed. A release in the same cycle takes priority over the rewind for rcptr: rcptr <= rptr + yumi_i and rptr <= that same value, i.e. a no-op replay.
- Illegal inputs (simulation assertions, disabled during reset):
  - w_commit_i & w_drop_i asserted together.
  - yumi_i & ~v_o.
  - ready_THEN_valid_p=1 with v_i & ~ready_o.
- Wrap-around: pointers wrap naturally. Full and empty must be distinguished by the wrap bit; no els-1 capacity limit applies.
- Simultaneous events: enq, w_commit/w_drop, yumi and r_release/r_rewind in the same cycle are all legal and act independently, except as stated above.
- Reset mid-operation: all pointers clear in that cycle. Uncommitted and unreleased data is lost.

Test Plan:
- Basic commit, lg_size_p=2, width_p=8: enq 0x11, 0x22 with commit on the second -> v_o=0 until the next cycle, then data_o=0x11, then 0x22 after yumi; commit_els_o goes 2,1,0.
- Drop: enq A; commit; enq B, C; drop; enq D; commit -> reader sees A, D only; free_els_o returns to 4 after releases.
- Full then release: fill 4 committed; yumi all 4 without release -> ready_o=0 throughout; r_release_i -> ready_o=1 the next cycle, free_els_o=4.
- Rewind/replay: enq and commit 1, 2, 3; yumi 1, 2; rewind with a yumi in the same cycle -> data_o=1 again; release after 1, 2 replay -> free_els_o=3.
- Wrap stress: random enq/commit/drop/yumi/release/rewind for 10k cycles against a scoreboard model, with lg_size_p=1 and lg_size_p=3 -> no ordering error, invariants hold, 4-pointer wrap exercised at least 50 times.
- Reset mid-stream: reset with 3 uncommitted and 2 committed-unread entries -> next cycle v_o=0, ready_o=1, free_els_o=els.
